cache_refill_arbiter: RTL and testbench
=======================================

CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, icache always wins.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ic_rrdy  output  1  icache port may issue a refill request.
REQ-005 ic_ren  input  4  icache read enable; nonzero = request.
REQ-006 ic_raddr  input  32  icache line address.
REQ-007 ic_rvalid  output  1  one-cycle pulse; icache line delivered.
REQ-008 ic_rdata  output  128  icache line data.
REQ-009 dc_rrdy, dc_ren, dc_raddr, dc_rvalid, dc_rdata: dcache port; same directions, widths and meanings as REQ-004..008.
REQ-010 mem_arvalid  output  1  read address valid.
REQ-011 mem_araddr  output  32  read address, bits [3:0] forced to 0.
REQ-012 mem_arlen  output  8  burst length, constant 3 (4 beats).
REQ-013 mem_arready  input  1  address accepted.
REQ-014 mem_rvalid  input  1  read beat valid.
REQ-015 mem_rdata  input  32  read beat data.
REQ-016 mem_rlast  input  1  last beat marker.
REQ-017 mem_rready  output  1  beat accept.
REQ-018 protocol_err  output  1  sticky; rlast mismatch seen.

Function
REQ-019 Request accepted on port p when p_rrdy=1 and p_ren!=0; address latched with [3:0] zeroed, pend_p set on next edge.
REQ-020 p_rrdy=0 whenever pend_p=1 or p is current owner; p_ren ignored while p_rrdy=0.
REQ-021 FSM states: IDLE, ADDR, DATA, RESP.
REQ-022 IDLE: if any pend set, pick owner, go ADDR next cycle; else stay.
REQ-023 Arbitration: single pend wins; both pending with RR_EN=1 -> requester not granted last wins; first tie after reset -> icache; RR_EN=0 -> icache.
REQ-024 ADDR: mem_arvalid=1, mem_araddr = owner address; on mem_arready=1 clear owner pend, go DATA.
REQ-025 DATA: mem_rready=1; each mem_rvalid beat k (0..3) written to line bits [32k+31:32k]; 2-bit beat counter increments per beat.
REQ-026 Completion on 4th accepted beat regardless of rlast; go RESP.
REQ-027 protocol_err set if mem_rlast=1 on beats 0..2 or mem_rlast=0 on beat 3; cleared only by reset.
REQ-028 RESP: owner p_rvalid=1 exactly one cycle, p_rdata = assembled line; go IDLE; owner p_rrdy=1 the following cycle.
REQ-029 Non-owner rvalid held 0; rdata outputs may hold stale line data when rvalid=0.
REQ-030 Request from other port during any state latched; serviced next IDLE pass.
REQ-031 Latency, uncontended, zero wait states: request edge T -> arvalid at T+2 -> beats T+3..T+6 -> rvalid T+7.
REQ-032 At most one burst outstanding; no new arvalid before RESP.

Reset
REQ-033 rst in any state: next edge FSM=IDLE, pend_ic=pend_dc=0, beat counter=0, last-grant=dcache, protocol_err=0.
REQ-034 Outputs after reset: ic_rrdy=dc_rrdy=1, rvalids=0, mem_arvalid=0, mem_rready=0, mem_araddr=0, rdata=0, mem_arlen=3.
REQ-035 Reset mid-burst drops the burst; no rvalid issued for it.

Structure
REQ-036 Shared package holds FSM state enum, LINE_BEATS=4, ARLEN=8'd3, port index constants (IC=0, DC=1).
REQ-037 One sub-module: line_assembler (beat counter, 128-bit shift-in buffer, rlast check).

Verification
REQ-038 ic_ren=4'hF, ic_raddr=0x1C00_0014, zero-wait memory -> araddr=0x1C00_0010 at T+2, ic_rvalid at T+7, rdata={w3,w2,w1,w0}.
REQ-039 ic and dc requests same cycle, RR_EN=1 -> icache first, dcache burst next; repeat tie -> dcache first.
REQ-040 dc request during icache DATA -> dc_rrdy=0 next cycle, dc burst starts after ic RESP, ic_rvalid never overlaps dc_rvalid.
REQ-041 mem_rvalid gaps of 2 cycles between beats -> data assembled correctly, rvalid once after 4th beat.
REQ-042 mem_rlast on beat 1 -> protocol_err=1 sticky, line still delivered after beat 3.
REQ-043 rst asserted in DATA after 2 beats -> next cycle IDLE, both rrdy=1, no rvalid for aborted burst.

Source files
------------

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared definitions for the cache refill arbiter.
// Holds the refill FSM state encoding, the line geometry (four 32-bit beats
// per 128-bit line), the fixed burst length presented on the memory read
// address channel, and the port index constants used for ownership and
// round-robin bookkeeping.
package cache_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int         LINE_BEATS = 4;
  localparam logic [1:0] LAST_BEAT  = 2'(LINE_BEATS - 1);
  localparam logic [7:0] ARLEN      = 8'd3;

  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;

  // Refills are always line aligned, so the byte offset within the
  // 16-byte line is dropped as soon as an address is captured.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFF0;
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_line_assembler.sv
// Line assembler for the refill data path.
// Collects four accepted read beats into one 128-bit line, beat 0 ending up
// in bits [31:0] and beat 3 in bits [127:96]. It also flags, stickily, any
// burst whose rlast marker does not sit exactly on the fourth beat.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   beat_i          a read beat is accepted this cycle
//   beat_data_i     32-bit beat payload
//   beat_last_i     rlast marker for the beat
//   line_o          assembled line (holds its value between bursts)
//   done_o          the beat accepted this cycle completes the line
//   protocol_err_o  sticky rlast mismatch flag
module cache_refill_arbiter_line_assembler
  import cache_refill_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         beat_i,
  input  logic [31:0]  beat_data_i,
  input  logic         beat_last_i,
  output logic [127:0] line_o,
  output logic         done_o,
  output logic         protocol_err_o
);

  logic [1:0]   beat_cnt_q;
  logic [127:0] line_q;
  logic         err_q;

  // Beats shift in from the top, so after four beats the first one has
  // travelled down to the least significant word. The counter wraps
  // naturally back to zero on the fourth beat, ready for the next burst.
  // Completion is decided by the count alone; rlast only feeds the error
  // flag, so a misbehaving slave can never stretch or shorten a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= 2'd0;
      line_q     <= '0;
      err_q      <= 1'b0;
    end else if (beat_i) begin
      beat_cnt_q <= beat_cnt_q + 2'd1;
      line_q     <= {beat_data_i, line_q[127:32]};
      if (beat_last_i != (beat_cnt_q == LAST_BEAT)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign done_o         = beat_i && (beat_cnt_q == LAST_BEAT);
  assign line_o         = line_q;
  assign protocol_err_o = err_q;

endmodule

// File: rtl/cache_refill_arbiter.sv
// Refill arbiter shared by the instruction and data caches.
// Each cache port may post one line refill at a time. Posted requests are
// held as pending flags with their line-aligned addresses; a four-state FSM
// picks an owner, issues a single 4-beat read burst, assembles the line and
// returns it to the owner with a one-cycle rvalid pulse.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   ic_rrdy/dc_rrdy              port may post a refill request
//   ic_ren/dc_ren, *_raddr       request (nonzero enable) and line address
//   ic_rvalid/dc_rvalid, *_rdata line delivered (one cycle) and its data
//   mem_ar*                      read address channel (burst length fixed)
//   mem_r*                       read data channel
//   protocol_err                 sticky rlast mismatch flag
// Parameter RR_EN: 1 = round-robin between simultaneous requests,
//                  0 = icache always wins.
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  output logic         ic_rrdy,
  input  logic [3:0]   ic_ren,
  input  logic [31:0]  ic_raddr,
  output logic         ic_rvalid,
  output logic [127:0] ic_rdata,
  output logic         dc_rrdy,
  input  logic [3:0]   dc_ren,
  input  logic [31:0]  dc_raddr,
  output logic         dc_rvalid,
  output logic [127:0] dc_rdata,
  output logic         mem_arvalid,
  output logic [31:0]  mem_araddr,
  output logic [7:0]   mem_arlen,
  input  logic         mem_arready,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_rlast,
  output logic         mem_rready,
  output logic         protocol_err
);

  state_e       state_q, state_d;
  logic         pend_ic_q, pend_ic_d;
  logic         pend_dc_q, pend_dc_d;
  logic         owner_q, owner_d;
  logic         last_grant_q, last_grant_d;
  logic [31:0]  ic_addr_q, ic_addr_d;
  logic [31:0]  dc_addr_q, dc_addr_d;
  logic         busy;
  logic         ic_acc, dc_acc;
  logic         grant;
  logic         beat;
  logic         line_done;
  logic [127:0] line;

  // A port stays blocked from the moment it posts until the cycle after its
  // own RESP; owner_q is only meaningful outside IDLE, hence the busy gate.
  assign busy    = (state_q != IDLE);
  assign ic_rrdy = !pend_ic_q && !(busy && (owner_q == IC));
  assign dc_rrdy = !pend_dc_q && !(busy && (owner_q == DC));
  assign ic_acc  = ic_rrdy && (ic_ren != 4'h0);
  assign dc_acc  = dc_rrdy && (dc_ren != 4'h0);

  assign beat      = mem_rvalid && mem_rready;
  assign mem_arlen = ARLEN;
  assign ic_rdata  = line;
  assign dc_rdata  = line;

  // Owner selection for the next IDLE exit. On a tie the port that did not
  // win last time goes first; last_grant_q starts at DC so the first tie
  // after reset favours the icache.
  always_comb begin
    grant = DC;
    if (pend_ic_q && pend_dc_q) begin
      grant = (RR_EN && (last_grant_q == IC)) ? DC : IC;
    end else if (pend_ic_q) begin
      grant = IC;
    end
  end

  // Next-state and output logic. New requests are captured in every state,
  // so a port that posts mid-burst is simply picked up on the next IDLE pass.
  always_comb begin
    state_d      = state_q;
    pend_ic_d    = pend_ic_q || ic_acc;
    pend_dc_d    = pend_dc_q || dc_acc;
    ic_addr_d    = ic_acc ? line_addr(ic_raddr) : ic_addr_q;
    dc_addr_d    = dc_acc ? line_addr(dc_raddr) : dc_addr_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_arvalid  = 1'b0;
    mem_araddr   = 32'h0;
    mem_rready   = 1'b0;
    ic_rvalid    = 1'b0;
    dc_rvalid    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_ic_q || pend_dc_q) begin
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        mem_arvalid = 1'b1;
        mem_araddr  = (owner_q == IC) ? ic_addr_q : dc_addr_q;
        if (mem_arready) begin
          if (owner_q == IC) begin
            pend_ic_d = 1'b0;
          end else begin
            pend_dc_d = 1'b0;
          end
          state_d = DATA;
        end
      end
      DATA: begin
        mem_rready = 1'b1;
        if (line_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        ic_rvalid = (owner_q == IC);
        dc_rvalid = (owner_q == DC);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset abandons any burst in flight: the FSM returns to
  // IDLE without a RESP, so the aborted line is never delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_ic_q    <= 1'b0;
      pend_dc_q    <= 1'b0;
      owner_q      <= IC;
      last_grant_q <= DC;
      ic_addr_q    <= 32'h0;
      dc_addr_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pend_ic_q    <= pend_ic_d;
      pend_dc_q    <= pend_dc_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ic_addr_q    <= ic_addr_d;
      dc_addr_q    <= dc_addr_d;
    end
  end

  cache_refill_arbiter_line_assembler u_line_assembler (
    .clk            (clk),
    .rst            (rst),
    .beat_i         (beat),
    .beat_data_i    (mem_rdata),
    .beat_last_i    (mem_rlast),
    .line_o         (line),
    .done_o         (line_done),
    .protocol_err_o (protocol_err)
  );

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed testbench for cache_refill_arbiter.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled on the falling edge. Every expected value is written out by hand
// or built from the beat base value used to drive the memory side.
module tb_cache_refill_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_rrdy, dc_rrdy;
  logic [3:0]   ic_ren, dc_ren;
  logic [31:0]  ic_raddr, dc_raddr;
  logic         ic_rvalid, dc_rvalid;
  logic [127:0] ic_rdata, dc_rdata;
  logic         mem_arvalid;
  logic [31:0]  mem_araddr;
  logic [7:0]   mem_arlen;
  logic         mem_arready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         mem_rlast;
  logic         mem_rready;
  logic         protocol_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_refill_arbiter #(.RR_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_rrdy      (ic_rrdy),
    .ic_ren       (ic_ren),
    .ic_raddr     (ic_raddr),
    .ic_rvalid    (ic_rvalid),
    .ic_rdata     (ic_rdata),
    .dc_rrdy      (dc_rrdy),
    .dc_ren       (dc_ren),
    .dc_raddr     (dc_raddr),
    .dc_rvalid    (dc_rvalid),
    .dc_rdata     (dc_rdata),
    .mem_arvalid  (mem_arvalid),
    .mem_araddr   (mem_araddr),
    .mem_arlen    (mem_arlen),
    .mem_arready  (mem_arready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_rlast    (mem_rlast),
    .mem_rready   (mem_rready),
    .protocol_err (protocol_err)
  );

  // The two delivery pulses must never coincide.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      if ((ic_rvalid === 1'b1) && (dc_rvalid === 1'b1)) begin
        bad++;
        $display("[TB] FAIL rvalid_overlap at %0t: ic=%0b dc=%0b want never both 1", $time, ic_rvalid, dc_rvalid);
      end
    end
  end

  // Expected line for a burst whose beats were base, base+1, base+2, base+3.
  function automatic logic [127:0] exp_line(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives four beats, each preceded by 'gap' idle cycles. Beat k carries
  // base+k; rlast is on beat 3 and additionally on beat badLast (if 0..2).
  // Entered in the ADDR cycle; returns in the cycle of the last beat.
  task automatic drive_beats(input logic [31:0] base, input int gap, input int badLast);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        next_cycle();
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
      end
      next_cycle();
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(k);
      mem_rlast  = (k == 3) || (k == badLast);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ic_ren = 4'h0; dc_ren = 4'h0; ic_raddr = 32'h0; dc_raddr = 32'h0;
    mem_arready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ic_rrdy !== 1'b1) begin bad++; $display("[TB] FAIL rst_ic_rrdy got=%0b want=1", ic_rrdy); end
    total++; if (dc_rrdy !== 1'b1) begin bad++; $display("[TB] FAIL rst_dc_rrdy got=%0b want=1", dc_rrdy); end
    total++; if (ic_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_ic_rvalid got=%0b want=0", ic_rvalid); end
    total++; if (dc_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_dc_rvalid got=%0b want=0", dc_rvalid); end
    total++; if (mem_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_arvalid got=%0b want=0", mem_arvalid); end
    total++; if (mem_rready !== 1'b0) begin bad++; $display("[TB] FAIL rst_rready got=%0b want=0", mem_rready); end
    total++; if (mem_araddr !== 32'h0) begin bad++; $display("[TB] FAIL rst_araddr got=%h want=0", mem_araddr); end
    total++; if (mem_arlen !== 8'd3) begin bad++; $display("[TB] FAIL rst_arlen got=%0d want=3", mem_arlen); end
    total++; if (ic_rdata !== 128'h0) begin bad++; $display("[TB] FAIL rst_ic_rdata got=%h want=0", ic_rdata); end
    total++; if (dc_rdata !== 128'h0) begin bad++; $display("[TB] FAIL rst_dc_rdata got=%h want=0", dc_rdata); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_protocol_err got=%0b want=0", protocol_err); end
    next_cycle();
    rst = 1'b0;
  endtask

  // Simultaneous requests. With last grant = dcache (first tie after reset)
  // the icache goes first; with last grant = icache the dcache goes first.
  task automatic test_tie(input bit dcFirst, input logic [31:0] baseA, input logic [31:0] baseB);
    logic [31:0] firstAddr, secondAddr;
    firstAddr  = dcFirst ? 32'h2000_00A0 : 32'h0000_1230;
    secondAddr = dcFirst ? 32'h0000_1230 : 32'h2000_00A0;
    next_cycle();
    ic_ren = 4'h3; ic_raddr = 32'h0000_1238;
    dc_ren = 4'h1; dc_raddr = 32'h2000_00AF;
    next_cycle();
    ic_ren = 4'h0; dc_ren = 4'h0;
    @(negedge clk);
    total++; if ({ic_rrdy, dc_rrdy} !== 2'b00) begin bad++; $display("[TB] FAIL tie_pending_rrdy got=%b want=00", {ic_rrdy, dc_rrdy}); end
    next_cycle();
    @(negedge clk);
    total++; if (mem_arvalid !== 1'b1 || mem_araddr !== firstAddr) begin bad++; $display("[TB] FAIL tie_first_addr got=%0b/%h want=1/%h", mem_arvalid, mem_araddr, firstAddr); end
    drive_beats(baseA, 0, -1);
    next_cycle();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    total++; if ({ic_rvalid, dc_rvalid} !== (dcFirst ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL tie_first_rvalid got=%b want=%b", {ic_rvalid, dc_rvalid}, (dcFirst ? 2'b01 : 2'b10)); end
    total++; if (ic_rdata !== exp_line(baseA)) begin bad++; $display("[TB] FAIL tie_first_data got=%h want=%h", ic_rdata, exp_line(baseA)); end
    next_cycle();
    @(negedge clk);
    total++; if (mem_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL tie_idle_arvalid got=%0b want=0", mem_arvalid); end
    next_cycle();
    @(negedge clk);
    total++; if (mem_arvalid !== 1'b1 || mem_araddr !== secondAddr) begin bad++; $display("[TB] FAIL tie_second_addr got=%0b/%h want=1/%h", mem_arvalid, mem_araddr, secondAddr); end
    drive_beats(baseB, 0, -1);
    next_cycle();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    total++; if ({ic_rvalid, dc_rvalid} !== (dcFirst ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL tie_second_rvalid got=%b want=%b", {ic_rvalid, dc_rvalid}, (dcFirst ? 2'b10 : 2'b01)); end
    total++; if (dc_rdata !== exp_line(baseB)) begin bad++; $display("[TB] FAIL tie_second_data got=%h want=%h", dc_rdata, exp_line(baseB)); end
    next_cycle();
    @(negedge clk);
    total++; if ({ic_rrdy, dc_rrdy} !== 2'b11) begin bad++; $display("[TB] FAIL tie_end_rrdy got=%b want=11", {ic_rrdy, dc_rrdy}); end
  endtask

  // Uncontended icache refill with zero-wait memory: request in cycle T,
  // arvalid in T+2, beats T+3..T+6, rvalid in T+7.
  task automatic test_basic();
    next_cycle();
    ic_ren = 4'hF; ic_raddr = 32'h1C00_0014;
    @(negedge clk);
    total++; if (ic_rrdy !== 1'b1) begin bad++; $display("[TB] FAIL basic_rrdy_T got=%0b want=1", ic_rrdy); end
    next_cycle();
    ic_ren = 4'h0;
    @(negedge clk);
    total++; if (ic_rrdy !== 1'b0 || mem_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL basic_T1 rrdy/arvalid got=%0b/%0b want=0/0", ic_rrdy, mem_arvalid); end
    next_cycle();
    @(negedge clk);
    total++; if (mem_arvalid !== 1'b1) begin bad++; $display("[TB] FAIL basic_T2_arvalid got=%0b want=1", mem_arvalid); end
    total++; if (mem_araddr !== 32'h1C00_0010) begin bad++; $display("[TB] FAIL basic_T2_araddr got=%h want=1c000010", mem_araddr); end
    drive_beats(32'hC0DE_0000, 0, -1);
    @(negedge clk);
    total++; if (ic_rvalid !== 1'b0 || mem_rready !== 1'b1) begin bad++; $display("[TB] FAIL basic_T6 rvalid/rready got=%0b/%0b want=0/1", ic_rvalid, mem_rready); end
    next_cycle();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    total++; if (ic_rvalid !== 1'b1 || dc_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL basic_T7_rvalid got ic=%0b dc=%0b want ic=1 dc=0", ic_rvalid, dc_rvalid); end
    total++; if (ic_rdata !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin bad++; $display("[TB] FAIL basic_T7_rdata got=%h want=c0de0003c0de0002c0de0001c0de0000", ic_rdata); end
    total++; if (ic_rrdy !== 1'b0) begin bad++; $display("[TB] FAIL basic_T7_rrdy got=%0b want=0", ic_rrdy); end
    next_cycle();
    @(negedge clk);
    total++; if (ic_rvalid !== 1'b0 || ic_rrdy !== 1'b1) begin bad++; $display("[TB] FAIL basic_T8 rvalid/rrdy got=%0b/%0b want=0/1", ic_rvalid, ic_rrdy); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("[TB] FAIL basic_protocol_err got=%0b want=0", protocol_err); end
  endtask

  // dcache posts while the icache burst is in DATA; it is blocked from the
  // next cycle and its burst follows the icache RESP.
  task automatic test_overlap();
    next_cycle();
    ic_ren = 4'h1; ic_raddr = 32'h0000_8008;
    next_cycle();
    ic_ren = 4'h0;
    next_cycle();
    @(negedge clk);
    total++; if (mem_araddr !== 32'h0000_8000) begin bad++; $display("[TB] FAIL ovl_ic_araddr got=%h want=00008000", mem_araddr); end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      mem_rvalid = 1'b1; mem_rdata = 32'h8800_0000 + 32'(k); mem_rlast = (k == 3);
      dc_ren = (k == 1) ? 4'h2 : 4'h0;
      dc_raddr = 32'h3000_0044;
      @(negedge clk);
      if (k == 1) begin
        total++; if (dc_rrdy !== 1'b1) begin bad++; $display("[TB] FAIL ovl_dc_rrdy_req got=%0b want=1", dc_rrdy); end
      end
      if (k == 2) begin
        total++; if (dc_rrdy !== 1'b0) begin bad++; $display("[TB] FAIL ovl_dc_rrdy_next got=%0b want=0", dc_rrdy); end
      end
    end
    next_cycle();
    mem_rvalid = 1'b0; mem_rlast = 1'b0; dc_ren = 4'h0;
    @(negedge clk);
    total++; if ({ic_rvalid, dc_rvalid} !== 2'b10) begin bad++; $display("[TB] FAIL ovl_ic_resp got=%b want=10", {ic_rvalid, dc_rvalid}); end
    total++; if (ic_rdata !== exp_line(32'h8800_0000)) begin bad++; $display("[TB] FAIL ovl_ic_data got=%h want=%h", ic_rdata, exp_line(32'h8800_0000)); end
    next_cycle();
    @(negedge clk);
    total++; if (dc_rrdy !== 1'b0 || mem_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL ovl_idle rrdy/arvalid got=%0b/%0b want=0/0", dc_rrdy, mem_arvalid); end
    next_cycle();
    @(negedge clk);
    total++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h3000_0040) begin bad++; $display("[TB] FAIL ovl_dc_addr got=%0b/%h want=1/30000040", mem_arvalid, mem_araddr); end
    drive_beats(32'h9900_0000, 0, -1);
    next_cycle();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    total++; if ({ic_rvalid, dc_rvalid} !== 2'b01) begin bad++; $display("[TB] FAIL ovl_dc_resp got=%b want=01", {ic_rvalid, dc_rvalid}); end
    total++; if (dc_rdata !== exp_line(32'h9900_0000)) begin bad++; $display("[TB] FAIL ovl_dc_data got=%h want=%h", dc_rdata, exp_line(32'h9900_0000)); end
    next_cycle();
  endtask

  // Two idle cycles before every beat; rvalid must appear only once, after
  // the fourth beat.
  task automatic test_gaps();
    int pulses;
    pulses = 0;
    next_cycle();
    dc_ren = 4'h8; dc_raddr = 32'h4000_001F;
    next_cycle();
    dc_ren = 4'h0;
    next_cycle();
    @(negedge clk);
    total++; if (mem_araddr !== 32'h4000_0010) begin bad++; $display("[TB] FAIL gap_araddr got=%h want=40000010", mem_araddr); end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 3; g++) begin
        next_cycle();
        mem_rvalid = (g == 2); mem_rdata = 32'h4444_0000 + 32'(k); mem_rlast = (g == 2) && (k == 3);
        @(negedge clk);
        if (dc_rvalid === 1'b1) pulses++;
        total++; if (mem_rready !== 1'b1) begin bad++; $display("[TB] FAIL gap_rready beat=%0d got=%0b want=1", k, mem_rready); end
      end
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL gap_early_rvalid got=%0d pulses want=0", pulses); end
    next_cycle();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    total++; if (dc_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL gap_resp got=%0b want=1", dc_rvalid); end
    total++; if (dc_rdata !== 128'h44440003_44440002_44440001_44440000) begin bad++; $display("[TB] FAIL gap_data got=%h want=44440003444400024444000144440000", dc_rdata); end
    next_cycle();
    @(negedge clk);
    total++; if (dc_rvalid !== 1'b0 || dc_rrdy !== 1'b1) begin bad++; $display("[TB] FAIL gap_after rvalid/rrdy got=%0b/%0b want=0/1", dc_rvalid, dc_rrdy); end
  endtask

  // rlast on beat 1: error flag goes up and stays, line still completes.
  task automatic test_rlast();
    next_cycle();
    ic_ren = 4'h4; ic_raddr = 32'h5000_0008;
    next_cycle();
    ic_ren = 4'h0;
    next_cycle();
    drive_beats(32'h5555_0000, 0, 1);
    next_cycle();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    total++; if (protocol_err !== 1'b1) begin bad++; $display("[TB] FAIL rlast_err got=%0b want=1", protocol_err); end
    total++; if (ic_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL rlast_rvalid got=%0b want=1", ic_rvalid); end
    total++; if (ic_rdata !== exp_line(32'h5555_0000)) begin bad++; $display("[TB] FAIL rlast_data got=%h want=%h", ic_rdata, exp_line(32'h5555_0000)); end
    repeat (3) next_cycle();
    @(negedge clk);
    total++; if (protocol_err !== 1'b1) begin bad++; $display("[TB] FAIL rlast_sticky got=%0b want=1", protocol_err); end
  endtask

  // Reset after two beats: the burst is dropped, no rvalid, and a following
  // refill assembles cleanly from beat 0.
  task automatic test_abort();
    int pulses;
    pulses = 0;
    next_cycle();
    ic_ren = 4'h2; ic_raddr = 32'h6000_0030;
    next_cycle();
    ic_ren = 4'h0;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      mem_rvalid = 1'b1; mem_rdata = 32'h6666_0000 + 32'(k); mem_rlast = 1'b0;
    end
    next_cycle();
    mem_rvalid = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++; if ({ic_rrdy, dc_rrdy} !== 2'b11) begin bad++; $display("[TB] FAIL abort_rrdy got=%b want=11", {ic_rrdy, dc_rrdy}); end
    total++; if (mem_rready !== 1'b0 || mem_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL abort_idle rready/arvalid got=%0b/%0b want=0/0", mem_rready, mem_arvalid); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("[TB] FAIL abort_err_clear got=%0b want=0", protocol_err); end
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge clk);
      if (ic_rvalid === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL abort_rvalid got=%0d pulses want=0", pulses); end
    next_cycle();
    ic_ren = 4'h1; ic_raddr = 32'h7000_0004;
    next_cycle();
    ic_ren = 4'h0;
    next_cycle();
    @(negedge clk);
    total++; if (mem_araddr !== 32'h7000_0000) begin bad++; $display("[TB] FAIL abort_next_araddr got=%h want=70000000", mem_araddr); end
    drive_beats(32'h7777_0000, 0, -1);
    next_cycle();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    total++; if (ic_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL abort_next_rvalid got=%0b want=1", ic_rvalid); end
    total++; if (ic_rdata !== exp_line(32'h7777_0000)) begin bad++; $display("[TB] FAIL abort_next_data got=%h want=%h", ic_rdata, exp_line(32'h7777_0000)); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("[TB] FAIL abort_next_err got=%0b want=0", protocol_err); end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    $display("[TB] starting cache_refill_arbiter directed tests");
    test_reset();
    test_tie(1'b0, 32'h1111_0000, 32'h2222_0000);
    test_basic();
    test_tie(1'b1, 32'h3333_0000, 32'hABCD_0000);
    test_overlap();
    test_gaps();
    test_rlast();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
